// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_cond_pkg
// Purpose  : Shared types and helpers for the input conditioner.
//            - state_e   : debounce FSM state encoding
//            - cnt_width : width of a counter that must hold 0..n
// Revision : 1.0  initial release
// ============================================================================
package input_cond_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_e;

    // Width needed to hold the values 0..n. Never returns less than 1 so a
    // degenerate parameter still yields a legal vector.
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_bit_sync2.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync2
// Purpose  : Two-flop synchroniser bringing a single asynchronous bit into
//            the clk domain. Reusable wherever a raw level must be sampled.
// Ports    : clk   - sampling clock (rising edge)
//            rst_n - asynchronous active-low reset, clears both stages
//            i_d   - raw asynchronous input
//            o_q   - synchronised output (two clocks of latency)
// Revision : 1.0  initial release
// ============================================================================
module bit_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Synchronises, debounces and edge-detects a raw asynchronous bit.
//            out_level is the clean level handed to the downstream detector;
//            rise/fall are registered one-cycle pulses on its transitions.
// Params   : STABLE_CYCLES - consecutive differing samples needed to flip (>=1)
//            GLITCH_W      - width of the rejected-glitch counter
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in         - raw asynchronous input
//            out_level  - debounced level
//            rise       - one-cycle pulse after each 0->1 of out_level
//            fall       - one-cycle pulse after each 1->0 of out_level
//            glitch_cnt - saturating count of rejected transitions
//                         (only when INPUT_COND_GLITCH_CNT_EN is defined)
// Config   : INPUT_COND_GLITCH_CNT_EN - adds glitch_cnt port and counter;
//            debounce behaviour is identical either way.
// Revision : 1.0  initial release
// ============================================================================
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in,
    output logic                out_level,
    output logic                rise,
    output logic                fall
`ifdef INPUT_COND_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int            CW         = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    // Reject illegal parameterisations at elaboration time.
    if (STABLE_CYCLES < 1 || GLITCH_W < 1) begin : g_param_check
        $error("input_conditioner: STABLE_CYCLES and GLITCH_W must be >= 1");
    end

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic w_s2;

    bit_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (in),
        .o_q   (w_s2)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    state_e        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_level_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        case (r_state)
            ST_STABLE: begin
                if (w_s2 == r_level) begin
                    w_cnt_nxt = '0;
                end else if (STABLE_CYCLES == 1) begin
                    // A single differing sample is already enough.
                    w_level_nxt = w_s2;
                    w_cnt_nxt   = '0;
                end else begin
                    // This sample is the first of the required run.
                    w_cnt_nxt   = C_CNT_ONE;
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_s2 == r_level) begin
                    // Input fell back before the run completed: glitch.
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_level_nxt = w_s2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            // Pulses are set on the same edge as the level flip so they are
            // high during the cycle that follows it; they are exclusive
            // because the level can only move one way per edge.
            r_rise  <= w_level_nxt & ~r_level;
            r_fall  <= ~w_level_nxt & r_level;
        end
    end

    assign out_level = r_level;
    assign rise      = r_rise;
    assign fall      = r_fall;

    // ------------------------------------------------------------------
    // Optional rejected-glitch counter
    // ------------------------------------------------------------------
`ifdef INPUT_COND_GLITCH_CNT_EN
    localparam logic [GLITCH_W-1:0] C_GLITCH_MAX = '1;

    logic [GLITCH_W-1:0] r_glitch_cnt;
    logic                w_glitch;

    // A PEND that returns to STABLE without flipping is a rejected glitch.
    assign w_glitch = (r_state == ST_PEND) && (w_s2 == r_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != C_GLITCH_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
# input_conditioner

Cleans a raw asynchronous single-bit input before it reaches the serial bit-stream consumer (the clk/in/out detector stage). It synchronises the input into the clk domain, debounces it, and presents a stable level plus one-cycle rise/fall pulses. The output `out_level` is the signal wired directly to the downstream stage's `in` port.

## Interface
- `STABLE_CYCLES`, 4: consecutive synchronised samples that must differ from the current level before the level flips. Legal range is ≥1.
- `GLITCH_W`, 8: width of the rejected-glitch counter. It is used only when the configuration macro is defined.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in` input 1: raw asynchronous input.
- `out_level` output 1: debounced level. Feeds the downstream `in`.
- `rise` output 1: one-cycle pulse on each 0→1 change of `out_level`.
- `fall` output 1: one-cycle pulse on each 1→0 change of `out_level`.
- `glitch_cnt` output GLITCH_W: saturating count of rejected transitions. Present only with the macro.

## Operation
- **Synchroniser:** two flops, `in` → `s1` → `s2`. Both reset to 0.
- **Debounce FSM:** two states, STABLE and PEND, with a counter `cnt` of width $clog2(STABLE_CYCLES+1).
  - **STABLE:**
    - If `s2 == out_level`: hold, with `cnt = 0`.
    - If `s2 != out_level` and STABLE_CYCLES==1: flip `out_level` on this edge and stay in STABLE.
    - Otherwise: `cnt ← 1` and go to PEND.
  - **PEND:**
    - If `s2 == out_level`: return to STABLE with `cnt ← 0`. This is a rejected glitch.
    - Else if `cnt == STABLE_CYCLES-1`: `out_level ← s2`, `cnt ← 0`, go to STABLE.
    - Else: `cnt ← cnt+1`.
- **Pulses:**
  - `rise` is registered and asserted for exactly the cycle after the edge where `out_level` goes 0→1.
  - `fall` is the same for 1→0.
  - `rise` and `fall` are never high together.
- **Reset:** asserting `rst_n` low at any time, including mid-PEND, forces the following immediately, with no clock needed:
  - `s1 = s2 = 0`
  - `out_level = 0`, `rise = 0`, `fall = 0`
  - `cnt = 0`, state STABLE
  - `glitch_cnt = 0`
- **After reset release:** a constant-high `in` produces a normal debounced rise.
- **Input toggling every cycle:** `out_level` never changes, and no pulses are produced.

## Timing
- **Latency:** `in` is sampled at edge E0 and reaches `s2` at E1. `out_level` changes at edge E(1+STABLE_CYCLES), and the matching pulse is high during the following cycle.
- **Minimum accepted pulse width:** STABLE_CYCLES clocks at `s2`. Shorter pulses are filtered.
- **Back-to-back transitions:** a reverse transition may begin counting on the edge right after the flip. The minimum spacing between `rise` and `fall` is STABLE_CYCLES cycles.
- **No handshake:** the downstream stage samples `out_level` every cycle.

## Configuration
- **Macro:** `INPUT_COND_GLITCH_CNT_EN`.
- **Defined:**
  - `glitch_cnt` exists.
  - It increments by 1 on every PEND→STABLE return without a flip.
  - It saturates at 2^GLITCH_W−1.
  - It resets to 0.
- **Undefined:**
  - The port and counter are absent.
  - Debounce behaviour is identical.

## Structure
- **Package `input_cond_pkg`:** holds the state enum (ST_STABLE=1'b0, ST_PEND=1'b1) and a `cnt_width(n)` function.
- **Sub-module `bit_sync2`:** the two-flop synchroniser with async active-low reset. It is reusable elsewhere in the design.
- **Top:** FSM, counter, pulse registers and the optional glitch counter.

## Test plan
- Reset held 5 cycles with `in=1`, then released → `out_level` rises 6 cycles after release (STABLE_CYCLES=4), and `rise` is high for exactly 1 cycle.
- `in` 0→1 held 10 cycles, then 1→0 → `rise` pulses at cycle 6 and `fall` pulses 6 cycles after the falling input. `out_level` is high for 10 cycles.
- `in` high for 3 cycles, then low → no change on `out_level`, `rise` or `fall`. With the macro, `glitch_cnt` = 1.
- `in` toggling every cycle for 50 cycles → `out_level` stays 0 and no pulses appear. With the macro and GLITCH_W=4, `glitch_cnt` saturates at 15.
- `rst_n` pulsed low mid-PEND (cycle 2 after an input rise) → all outputs 0 immediately. After release with `in=1`, the rise completes 6 cycles later.
- STABLE_CYCLES=1, `in` 0→1 → `out_level` rises 2 cycles after the sampling edge and `rise` pulses once.
